// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the PC, fetches 256-word instruction memory into a prefetch queue for decode.
// Optional FETCH_HALT_ZERO_EN: after queuing an all-zero word, fetching stops (DONE) until a redirect.
module imem_fetch_ctrl #(
    parameter logic [7:0] BOOT_PC = 8'd0,
    parameter int         DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [7:0]  inst_pc,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [7:0]    tag_q [DEPTH];
    logic [7:0]    tag_d [DEPTH];
    logic          pop, push, flush;

    assign imem_addr  = pc_q;
    assign inst_valid = cnt_q != '0;
    assign inst_data  = inst_valid ? data_q[rd_q] : '0;
    assign inst_pc    = inst_valid ? tag_q[rd_q] : '0;
    assign busy       = state_q != IDLE;
    assign flush      = redirect && state_q != IDLE;
    assign pop        = inst_valid && inst_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push       = state_q == RUN && !redirect && (cnt_q < FULL || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = RUN;
            pc_d    = redirect_pc;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (state_q == IDLE && start)
                state_d = RUN;
            if (push) begin
                data_d[wr_q] = imem_rdata;
                tag_d[wr_q]  = pc_q;
                wr_d         = wr_q + AW'(1);
                pc_d         = pc_q + 8'd1;
`ifdef FETCH_HALT_ZERO_EN
                if (imem_rdata == '0)
                    state_d = DONE;
`endif
            end
            if (pop)
                rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= BOOT_PC;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            data_q  <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: vector table, directed corner sequences and a randomized run against a queue model.
module tb_imem_fetch_ctrl;
    localparam int DEPTH = 2;

    logic        clk, rst, start, inst_ready, redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  addr_a, pc_a, addr_b, pc_b;
    logic [31:0] rdata_a, data_a, rdata_b, data_b;
    logic        valid_a, busy_a, valid_b, busy_b;
    logic [31:0] mem [256];
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    int         mst;
    logic [7:0] mpc;

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rdr;
        logic [7:0]  rpc;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] ed;
        logic [7:0]  ea;
        logic        eb;
        logic [7:0]  epcb;
    } vec_t;
    vec_t tbl[8];

    assign rdata_a = mem[addr_a];
    assign rdata_b = mem[addr_b];

    imem_fetch_ctrl #(.BOOT_PC(8'd0), .DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .start(start), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .inst_valid(valid_a), .inst_ready(inst_ready), .inst_data(data_a), .inst_pc(pc_a),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy_a));

    imem_fetch_ctrl #(.BOOT_PC(8'd254), .DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .start(start), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .inst_valid(valid_b), .inst_ready(inst_ready), .inst_data(data_b), .inst_pc(pc_b),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input int i);
        return i == 0 ? 32'h02328020 : i == 1 ? 32'h22340003 :
               (i >= 14 && i < 64) ? 32'h0 : {8'hA5, 8'(i), 16'h1234};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    task automatic model_check();
        chk("m_valid", 32'(valid_a), 32'(q.size() != 0));
        chk("m_pc", 32'(pc_a), q.size() != 0 ? 32'(q[0].pc) : 32'd0);
        chk("m_data", data_a, q.size() != 0 ? q[0].d : 32'd0);
        chk("m_addr", 32'(addr_a), 32'(mpc));
        chk("m_busy", 32'(busy_a), 32'(mst != 0));
    endtask

    task automatic model_step();
        logic p, pu;
        if (mst != 0 && redirect) begin
            q.delete();
            mpc = redirect_pc;
            mst = 1;
        end else begin
            p  = q.size() != 0 && inst_ready;
            pu = mst == 1 && (q.size() < DEPTH || p);
            if (p)
                void'(q.pop_front());
            if (pu) begin
                q.push_back('{mpc, mem[mpc]});
`ifdef FETCH_HALT_ZERO_EN
                if (mem[mpc] == 32'h0)
                    mst = 2;
`endif
                mpc = mpc + 8'd1;
            end
            if (mst == 0 && start)
                mst = 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = memw(i);
        rst = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
        #2;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_pc", 32'(pc_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'd254);
        adv();
        rst = 1'b0;

        // start, one word per cycle, then redirect to 8; u_b shows the 254,255,0,1 wrap
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 32'd0,  8'd0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 32'd0,  8'd0, 1'b1, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, mem[0], 8'd1, 1'b1, 8'd254};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, mem[1], 8'd2, 1'b1, 8'd255};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd2, mem[2], 8'd3, 1'b1, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'd8, 1'b1, 8'd3, mem[3], 8'd4, 1'b1, 8'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 32'd0,  8'd8, 1'b1, 8'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd8, mem[8], 8'd9, 1'b1, 8'd8};
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].st; inst_ready = tbl[i].rdy;
            redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), 32'(valid_a), 32'(tbl[i].ev));
            chk($sformatf("t%0d_pc", i), 32'(pc_a), 32'(tbl[i].epc));
            chk($sformatf("t%0d_data", i), data_a, tbl[i].ed);
            chk($sformatf("t%0d_addr", i), 32'(addr_a), 32'(tbl[i].ea));
            chk($sformatf("t%0d_busy", i), 32'(busy_a), 32'(tbl[i].eb));
            chk($sformatf("t%0d_pc_b", i), 32'(pc_b), 32'(tbl[i].epcb));
            adv();
        end
        redirect = 1'b0;

        // backpressure: ready low for 5 cycles after start
        pulse_rst();
        start = 1'b1; inst_ready = 1'b0;
        adv();
        start = 1'b0;
        adv();
        adv();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_addr_hold", 32'(addr_a), 32'd2);
            chk("bp_head", 32'(pc_a), 32'd0);
            adv();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_stream_pc", 32'(pc_a), 32'(k));
            chk("bp_stream_valid", 32'(valid_a), 32'd1);
            adv();
        end
        // queue now holds pcs 4,5: redirect drops both
        redirect = 1'b1; redirect_pc = 8'd8;
        @(negedge clk);
        chk("rd_head4", 32'(pc_a), 32'd4);
        chk("rd_addr6", 32'(addr_a), 32'd6);
        adv();
        redirect = 1'b0;
        @(negedge clk);
        chk("rd_flushed", 32'(valid_a), 32'd0);
        chk("rd_addr8", 32'(addr_a), 32'd8);
        adv();
        @(negedge clk);
        chk("rd_valid8", 32'(valid_a), 32'd1);
        chk("rd_pc8", 32'(pc_a), 32'd8);
        chk("rd_data8", data_a, mem[8]);
        adv();

        // fill the queue, then reset mid-stream
        inst_ready = 1'b0;
        adv();
        @(negedge clk);
        chk("full_addr", 32'(addr_a), 32'd11);
        chk("full_head", 32'(pc_a), 32'd9);
        adv();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_addr", 32'(addr_a), 32'd0);
        adv();
        rst = 1'b0;
        start = 1'b1; inst_ready = 1'b1;
        adv();
        start = 1'b0;
        adv();
        @(negedge clk);
        chk("restart_pc", 32'(pc_a), 32'd0);
        chk("restart_data", data_a, mem[0]);
        adv();
        @(negedge clk);
        chk("restart_pc1", 32'(pc_a), 32'd1);
        adv();

        // zero-word program end at pc 14
        pulse_rst();
        start = 1'b1; inst_ready = 1'b1;
        adv();
        start = 1'b0;
        adv();
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            chk("zp_pc", 32'(pc_a), 32'(k));
            adv();
        end
`ifdef FETCH_HALT_ZERO_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_valid", 32'(valid_a), 32'd0);
            chk("halt_addr", 32'(addr_a), 32'd15);
            chk("halt_busy", 32'(busy_a), 32'd1);
            adv();
        end
        redirect = 1'b1; redirect_pc = 8'd0;
        adv();
        redirect = 1'b0;
        @(negedge clk);
        chk("halt_rd_addr", 32'(addr_a), 32'd0);
        adv();
        @(negedge clk);
        chk("halt_refetch", data_a, 32'h02328020);
        chk("halt_refetch_pc", 32'(pc_a), 32'd0);
        adv();
`else
        @(negedge clk);
        chk("zero_nop_pc", 32'(pc_a), 32'd15);
        chk("zero_nop_data", data_a, 32'd0);
        chk("zero_nop_addr", 32'(addr_a), 32'd16);
        adv();
`endif

        // randomized run against the queue model
        pulse_rst();
        q.delete(); mpc = 8'd0; mst = 0;
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(0, 15) == 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 8'($urandom_range(0, 255));
            @(negedge clk);
            model_check();
            model_step();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
